// File: rtl/rv_iommu_apb_reg_demux.sv
// APB slave that decodes accesses into one of NUM_TARGETS register-bus
// targets, with alignment checking, a target-stall timeout and a saturating
// count of error responses.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   psel_i .. pstrb_i     APB request (setup/access phases)
//   prdata_o, pready_o,
//   pslverr_o             APB response, valid for one cycle in RESP
//   reg_req_o[NUM_TARGETS] per-target register request (only sel is valid)
//   reg_rsp_i[NUM_TARGETS] per-target register response
//   err_cnt_o             saturating count of error responses

package rv_iommu_apb_reg_demux_pkg;

  localparam int unsigned REG_AW = 32;
  localparam int unsigned REG_DW = 32;

  typedef struct packed {
    logic [REG_AW-1:0]   addr;
    logic                write;
    logic [REG_DW-1:0]   wdata;
    logic [REG_DW/8-1:0] wstrb;
    logic                valid;
  } reg_req_32_t;

  typedef struct packed {
    logic [REG_DW-1:0] rdata;
    logic              error;
    logic              ready;
  } reg_rsp_32_t;

endpackage

module rv_iommu_apb_reg_demux #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_TARGETS    = 2,
  // Element [i] belongs to target i (element 0 is the rightmost literal).
  parameter logic [NUM_TARGETS-1:0][ADDR_WIDTH-1:0] TARGET_BASE = {32'h0000_1000, 32'h0000_0000},
  parameter logic [NUM_TARGETS-1:0][ADDR_WIDTH-1:0] TARGET_MASK = {32'hFFFF_F000, 32'hFFFF_F000},
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter type reg_req_t = rv_iommu_apb_reg_demux_pkg::reg_req_32_t,
  parameter type reg_rsp_t = rv_iommu_apb_reg_demux_pkg::reg_rsp_32_t
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  psel_i,
  input  logic                                  penable_i,
  input  logic                                  pwrite_i,
  input  logic [ADDR_WIDTH-1:0]                 paddr_i,
  input  logic [DATA_WIDTH-1:0]                 pwdata_i,
  input  logic [DATA_WIDTH/8-1:0]               pstrb_i,
  output logic [DATA_WIDTH-1:0]                 prdata_o,
  output logic                                  pready_o,
  output logic                                  pslverr_o,
  output reg_req_t [NUM_TARGETS-1:0]            reg_req_o,
  input  reg_rsp_t [NUM_TARGETS-1:0]            reg_rsp_i,
  output logic [15:0]                           err_cnt_o
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned SEL_W  = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_e;

  state_e                      state_q, state_d;
  reg_req_t [NUM_TARGETS-1:0]  req_q, req_d;
  logic [SEL_W-1:0]            sel_q, sel_d;
  logic [TO_W-1:0]             to_cnt_q, to_cnt_d;
  logic [DATA_WIDTH-1:0]       prdata_q, prdata_d;
  logic                        pready_q, pready_d;
  logic                        pslverr_q, pslverr_d;
  logic [15:0]                 err_cnt_q, err_cnt_d;

  logic                        hit;
  logic [SEL_W-1:0]            hit_idx;
  logic                        misaligned;
  reg_req_t                    new_req;
  logic                        done;
  logic                        done_err;
  logic [DATA_WIDTH-1:0]       done_rdata;
  logic                        err_evt;

  // Window decode; scanning downwards lets the lowest matching index win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if ((paddr_i & TARGET_MASK[i]) == TARGET_BASE[i]) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  assign misaligned = (paddr_i[OFF_W-1:0] != '0);

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    req_d      = '0;
    sel_d      = sel_q;
    to_cnt_d   = to_cnt_q;
    prdata_d   = '0;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    err_cnt_d  = err_cnt_q;
    new_req    = '0;
    done       = 1'b0;
    done_err   = 1'b0;
    done_rdata = '0;
    err_evt    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (psel_i && penable_i) begin
          to_cnt_d = '0;
          if (misaligned || !hit) begin
            state_d   = ST_RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            err_evt   = 1'b1;
          end else begin
            new_req.addr   = paddr_i & ~TARGET_MASK[hit_idx];
            new_req.write  = pwrite_i;
            new_req.wdata  = pwdata_i;
            new_req.wstrb  = pwrite_i ? pstrb_i : '0;
            new_req.valid  = 1'b1;
            req_d[hit_idx] = new_req;
            sel_d          = hit_idx;
            state_d        = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        // Ready is checked before the timeout so a same-cycle ready wins.
        if (reg_rsp_i[sel_q].ready) begin
          done       = 1'b1;
          done_err   = reg_rsp_i[sel_q].error;
          done_rdata = req_q[sel_q].write ? '0 : reg_rsp_i[sel_q].rdata;
        end else if ((TIMEOUT_CYCLES != 0) && (to_cnt_d == TO_W'(TIMEOUT_CYCLES))) begin
          done     = 1'b1;
          done_err = 1'b1;
        end else begin
          req_d[sel_q] = req_q[sel_q];
        end

        if (done) begin
          err_evt = done_err;
          // A master that has already dropped psel gets no response phase.
          if (psel_i) begin
            state_d   = ST_RESP;
            pready_d  = 1'b1;
            pslverr_d = done_err;
            prdata_d  = done_rdata;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    if (err_evt && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      sel_q     <= '0;
      to_cnt_q  <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      sel_q     <= sel_d;
      to_cnt_q  <= to_cnt_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign reg_req_o = req_q;
  assign prdata_o  = prdata_q;
  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_rv_iommu_apb_reg_demux.sv
// Bench for rv_iommu_apb_reg_demux: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_rv_iommu_apb_reg_demux;
  import rv_iommu_apb_reg_demux_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [15:0] err_cnt;
  reg_req_32_t [1:0] reg_req;
  reg_rsp_32_t [1:0] rsp;

  int          tests = 0;
  int          fails = 0;
  int unsigned err_model = 0;

  logic [31:0] base_m [2] = '{32'h0000_0000, 32'h0000_1000};
  logic [31:0] mask_m [2] = '{32'hFFFF_F000, 32'hFFFF_F000};

  typedef struct {
    int          lat;
    int          vcnt;
    logic [31:0] prdata;
    logic        slverr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        write;
    int          tgt;
    logic        other_valid;
    int          pready_cycles;
  } obs_t;

  rv_iommu_apb_reg_demux #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst), .psel_i(psel), .penable_i(penable),
    .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .reg_req_o(reg_req), .reg_rsp_i(rsp), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic void bump_err(input logic e);
    if (e && err_model < 65535) err_model++;
  endfunction

  // Transaction-level expectation: decode, then either a target reply on
  // REQ cycle stall+1 or a timeout after TO cycles, whichever is first.
  function automatic obs_t model(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, input int stall, input logic rerr,
                                 input logic [31:0] rdata);
    obs_t e;
    int   tgt;
    tgt = -1;
    e.lat = 1; e.vcnt = 0; e.prdata = 0; e.slverr = 1; e.addr = 0; e.wdata = 0;
    e.wstrb = 0; e.write = 0; e.tgt = -1; e.other_valid = 0; e.pready_cycles = 1;
    if (addr % 4 == 0)
      for (int i = 0; i < 2; i++)
        if (tgt < 0 && (addr & mask_m[i]) == base_m[i]) tgt = i;
    if (tgt < 0) return e;
    e.tgt = tgt; e.addr = addr & ~mask_m[tgt]; e.wdata = wdata;
    e.wstrb = wr ? strb : 4'h0; e.write = wr;
    if (stall + 1 > TO) begin
      e.vcnt = TO; e.lat = TO + 1; e.slverr = 1; e.prdata = 0;
    end else begin
      e.vcnt = stall + 1; e.lat = stall + 2; e.slverr = rerr; e.prdata = wr ? 32'h0 : rdata;
    end
    return e;
  endfunction

  // Drives one APB transfer and plays the selected target; idle targets
  // assert ready/error noise that the DUT must ignore.
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int stall, input logic rerr,
                         input logic [31:0] rdata, output obs_t o);
    int nv;
    o.lat = -1; o.vcnt = 0; o.prdata = 0; o.slverr = 0; o.addr = 0; o.wdata = 0;
    o.wstrb = 0; o.write = 0; o.tgt = -1; o.other_valid = 0; o.pready_cycles = 0;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    @(negedge clk);
    penable = 1'b1;
    for (int n = 1; n <= 40 && o.lat < 0; n++) begin
      @(negedge clk);
      for (int t = 0; t < 2; t++) begin
        rsp[t].rdata = $urandom; rsp[t].error = 1'b1; rsp[t].ready = 1'b1;
      end
      nv = 0;
      for (int t = 0; t < 2; t++) begin
        if (reg_req[t].valid) begin
          nv++;
          if (o.vcnt == 0 && o.tgt < 0) begin
            o.tgt = t; o.addr = reg_req[t].addr; o.wdata = reg_req[t].wdata;
            o.wstrb = reg_req[t].wstrb; o.write = reg_req[t].write;
          end else if (t != o.tgt) o.other_valid = 1'b1;
        end
      end
      if (nv > 1) o.other_valid = 1'b1;
      if (nv > 0 && o.tgt >= 0 && reg_req[o.tgt].valid) begin
        o.vcnt++;
        rsp[o.tgt].ready = (o.vcnt == stall + 1);
        rsp[o.tgt].error = rerr;
        rsp[o.tgt].rdata = rdata;
      end
      if (pready) begin
        o.lat = n; o.prdata = prdata; o.slverr = pslverr; o.pready_cycles = 1;
        psel = 1'b0; penable = 1'b0;
      end
    end
    @(negedge clk);
    if (pready) o.pready_cycles++;
  endtask

  task automatic test_reset();
    rst = 1'b1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0; rsp = '0;
    repeat (3) @(negedge clk);
    tests++; if (pready !== 1'b0 || pslverr !== 1'b0) begin fails++; $display("FAIL reset_pready: got %b/%b want 0/0", pready, pslverr); end
    tests++; if (prdata !== 32'h0) begin fails++; $display("FAIL reset_prdata: got %h want 0", prdata); end
    tests++; if (err_cnt !== 16'h0) begin fails++; $display("FAIL reset_errcnt: got %h want 0", err_cnt); end
    tests++; if (reg_req[0].valid !== 1'b0 || reg_req[1].valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b%b want 00", reg_req[1].valid, reg_req[0].valid); end
    rst = 1'b0;
    @(negedge clk);
    tests++; if (pready !== 1'b0) begin fails++; $display("FAIL post_reset_pready: got %b want 0", pready); end
    err_model = 0;
  endtask

  task automatic test_write_target1();
    obs_t o;
    do_xfer(1'b1, 32'h1008, 32'hDEADBEEF, 4'b0011, 0, 1'b0, 32'h0, o);
    tests++; if (o.tgt !== 1) begin fails++; $display("FAIL wr_target: got %0d want 1", o.tgt); end
    tests++; if (o.addr !== 32'h8) begin fails++; $display("FAIL wr_addr: got %h want 00000008", o.addr); end
    tests++; if (o.wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_wdata: got %h want deadbeef", o.wdata); end
    tests++; if (o.wstrb !== 4'b0011 || o.write !== 1'b1) begin fails++; $display("FAIL wr_strb: got %b/%b want 0011/1", o.wstrb, o.write); end
    tests++; if (o.other_valid !== 1'b0) begin fails++; $display("FAIL wr_other_valid: got %b want 0", o.other_valid); end
    tests++; if (o.lat !== 2) begin fails++; $display("FAIL wr_latency: got %0d want 2", o.lat); end
    tests++; if (o.slverr !== 1'b0 || o.pready_cycles !== 1) begin fails++; $display("FAIL wr_resp: slverr %b pready_cycles %0d want 0/1", o.slverr, o.pready_cycles); end
  endtask

  task automatic test_read_stall();
    obs_t o;
    do_xfer(1'b0, 32'h0010, 32'h5555AAAA, 4'hF, 3, 1'b0, 32'h12345678, o);
    tests++; if (o.prdata !== 32'h12345678) begin fails++; $display("FAIL rd_data: got %h want 12345678", o.prdata); end
    tests++; if (o.slverr !== 1'b0 || o.pready_cycles !== 1) begin fails++; $display("FAIL rd_resp: slverr %b pready_cycles %0d want 0/1", o.slverr, o.pready_cycles); end
    tests++; if (o.lat !== 5 || o.vcnt !== 4) begin fails++; $display("FAIL rd_timing: lat %0d vcnt %0d want 5/4", o.lat, o.vcnt); end
    tests++; if (o.tgt !== 0 || o.wstrb !== 4'h0) begin fails++; $display("FAIL rd_req: tgt %0d wstrb %b want 0/0000", o.tgt, o.wstrb); end
    tests++; if (err_cnt !== 16'd0) begin fails++; $display("FAIL rd_errcnt: got %0d want 0", err_cnt); end
  endtask

  task automatic test_decode_errors();
    obs_t o;
    logic [31:0] addrs [2] = '{32'h0000_5000, 32'h0000_0002};
    for (int k = 0; k < 2; k++) begin
      do_xfer(1'b0, addrs[k], 32'h0, 4'hF, 0, 1'b0, 32'hCAFEF00D, o);
      bump_err(1'b1);
      tests++; if (o.lat !== 1 || o.slverr !== 1'b1 || o.prdata !== 32'h0) begin fails++; $display("FAIL dec_err_%0d: lat %0d slverr %b prdata %h want 1/1/0", k, o.lat, o.slverr, o.prdata); end
      tests++; if (o.vcnt !== 0) begin fails++; $display("FAIL dec_err_valid_%0d: got %0d valid cycles want 0", k, o.vcnt); end
    end
    tests++; if (err_cnt !== 16'd2) begin fails++; $display("FAIL dec_errcnt: got %0d want 2", err_cnt); end
  endtask

  task automatic test_timeout();
    obs_t o;
    do_xfer(1'b0, 32'h0000_0100, 32'h0, 4'hF, 1000, 1'b0, 32'h11112222, o);
    bump_err(1'b1);
    tests++; if (o.vcnt !== TO || o.lat !== TO + 1) begin fails++; $display("FAIL to_timing: vcnt %0d lat %0d want %0d/%0d", o.vcnt, o.lat, TO, TO + 1); end
    tests++; if (o.slverr !== 1'b1 || o.prdata !== 32'h0) begin fails++; $display("FAIL to_resp: slverr %b prdata %h want 1/0", o.slverr, o.prdata); end
    tests++; if (err_cnt !== 16'(err_model)) begin fails++; $display("FAIL to_errcnt: got %0d want %0d", err_cnt, err_model); end
    do_xfer(1'b0, 32'h0000_0100, 32'h0, 4'hF, TO - 1, 1'b0, 32'h33334444, o);
    tests++; if (o.slverr !== 1'b0 || o.prdata !== 32'h33334444) begin fails++; $display("FAIL to_edge: slverr %b prdata %h want 0/33334444", o.slverr, o.prdata); end
  endtask

  task automatic test_random();
    obs_t o, e;
    logic        wr, rerr;
    logic [31:0] a, wd, rd;
    logic [3:0]  st;
    int          stall;
    for (int it = 0; it < 24; it++) begin
      wr = 1'($urandom); wd = $urandom; rd = $urandom; st = 4'($urandom);
      stall = $urandom_range(0, 6); rerr = ($urandom_range(0, 3) == 0);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: begin a[31:12] = 20'h0; a[1:0] = 2'b00; end
        1: begin a[31:12] = 20'h1; a[1:0] = 2'b00; end
        2: a[1:0] = 2'b00;
        default: begin a[31:12] = 20'($urandom_range(0, 2)); a[1:0] = 2'($urandom_range(1, 3)); end
      endcase
      e = model(wr, a, wd, st, stall, rerr, rd);
      do_xfer(wr, a, wd, st, stall, rerr, rd, o);
      bump_err(e.slverr);
      tests++;
      if (o.lat !== e.lat || o.vcnt !== e.vcnt || o.slverr !== e.slverr || o.prdata !== e.prdata ||
          o.pready_cycles !== 1 || o.tgt !== e.tgt || o.other_valid !== 1'b0) begin
        fails++;
        $display("FAIL rand_%0d resp: addr %h got lat %0d vcnt %0d err %b rd %h tgt %0d pc %0d ov %b want lat %0d vcnt %0d err %b rd %h tgt %0d",
                 it, a, o.lat, o.vcnt, o.slverr, o.prdata, o.tgt, o.pready_cycles, o.other_valid,
                 e.lat, e.vcnt, e.slverr, e.prdata, e.tgt);
      end
      if (e.tgt >= 0) begin
        tests++;
        if (o.addr !== e.addr || o.wdata !== e.wdata || o.wstrb !== e.wstrb || o.write !== e.write) begin
          fails++;
          $display("FAIL rand_%0d req: got addr %h wd %h strb %b wr %b want addr %h wd %h strb %b wr %b",
                   it, o.addr, o.wdata, o.wstrb, o.write, e.addr, e.wdata, e.wstrb, e.write);
        end
      end
      tests++; if (err_cnt !== 16'(err_model)) begin fails++; $display("FAIL rand_%0d errcnt: got %0d want %0d", it, err_cnt, err_model); end
    end
  endtask

  task automatic test_abandon();
    obs_t o;
    int vc, pr;
    vc = 0; pr = 0;
    rsp = '0;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_1040;
    @(negedge clk);
    penable = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) begin psel = 1'b0; penable = 1'b0; end
      rsp = '0;
      if (reg_req[1].valid) begin
        vc++;
        if (vc == 3) begin rsp[1].ready = 1'b1; rsp[1].error = 1'b1; end
      end
      if (pready) pr++;
    end
    bump_err(1'b1);
    tests++; if (vc !== 3 || pr !== 0) begin fails++; $display("FAIL abandon: valid cycles %0d pready cycles %0d want 3/0", vc, pr); end
    tests++; if (err_cnt !== 16'(err_model)) begin fails++; $display("FAIL abandon_errcnt: got %0d want %0d", err_cnt, err_model); end
    do_xfer(1'b0, 32'h0000_1044, 32'h0, 4'hF, 0, 1'b0, 32'hA5A5_0001, o);
    tests++; if (o.lat !== 2 || o.prdata !== 32'hA5A5_0001 || o.slverr !== 1'b0) begin fails++; $display("FAIL after_abandon: lat %0d rd %h err %b want 2/a5a50001/0", o.lat, o.prdata, o.slverr); end
  endtask

  task automatic test_reset_mid_req();
    obs_t o;
    rsp = '0;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_0020;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    tests++; if (reg_req[0].valid !== 1'b1) begin fails++; $display("FAIL midrst_pre: valid %b want 1", reg_req[0].valid); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    err_model = 0;
    tests++; if (reg_req[0].valid !== 1'b0 || reg_req[1].valid !== 1'b0 || pready !== 1'b0) begin fails++; $display("FAIL midrst_out: valid %b%b pready %b want 00/0", reg_req[1].valid, reg_req[0].valid, pready); end
    tests++; if (err_cnt !== 16'h0) begin fails++; $display("FAIL midrst_errcnt: got %0d want 0", err_cnt); end
    do_xfer(1'b0, 32'h0000_0024, 32'h0, 4'hF, 1, 1'b0, 32'h0BAD_F00D, o);
    tests++; if (o.lat !== 3 || o.prdata !== 32'h0BAD_F00D || o.slverr !== 1'b0) begin fails++; $display("FAIL midrst_after: lat %0d rd %h err %b want 3/0badf00d/0", o.lat, o.prdata, o.slverr); end
  endtask

  task automatic test_err_saturate();
    obs_t o;
    logic [15:0] want [3] = '{16'hFFFE, 16'hFFFF, 16'hFFFF};
    @(negedge clk);
    force dut.err_cnt_q = 16'hFFFD;
    #1 release dut.err_cnt_q;
    err_model = 32'hFFFD;
    for (int k = 0; k < 3; k++) begin
      do_xfer(1'b1, 32'h0000_1000, $urandom, 4'hF, 0, 1'b1, 32'h0, o);
      bump_err(1'b1);
      tests++; if (o.slverr !== 1'b1 || o.prdata !== 32'h0) begin fails++; $display("FAIL sat_resp_%0d: err %b rd %h want 1/0", k, o.slverr, o.prdata); end
      tests++; if (err_cnt !== want[k] || err_cnt !== 16'(err_model)) begin fails++; $display("FAIL sat_cnt_%0d: got %h want %h", k, err_cnt, want[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_write_target1();
    test_read_stall();
    test_decode_errors();
    test_timeout();
    test_random();
    test_abandon();
    test_reset_mid_req();
    test_err_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
